morse_char_queue: RTL and testbench



---
 rtl/morse_char_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_morse_char_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_queue.sv
// -----------------------------------------------------------------------------
// morse_char_queue
//
// Buffered character sequencer sitting between the UART receiver and the
// ASCII-to-Morse translator / blinker path.
//
// Each rising edge of i_rx_ready delivers one byte. The byte is normalised:
// CR (0x0D) and LF (0x0A) are dropped, and lowercase a-z is folded to
// uppercase. All other bytes pass unchanged. Normalised bytes go into a
// DEPTH-entry circular FIFO. A small sequencer pops one character at a time
// and pulses o_start once the blinker reports idle. Only one character is in
// flight at a time. A character counts as sent when the blinker has gone busy
// and then idle again. It also counts as sent when the blinker never goes
// busy within BUSY_TIMEOUT cycles.
//
// Parameters
//   DEPTH         FIFO entries (power of two, >= 2)
//   BUSY_TIMEOUT  cycles to wait for the blinker to drop ready after o_start
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_rx_data    receiver byte, valid while i_rx_ready is high
//   i_rx_ready   receiver level flag; each rising edge is one new byte
//   i_blk_ready  blinker idle (1) / playing (0)
//   o_char       character for the translator, held until the next pop
//   o_start      one-cycle pulse: blinker should load o_char's Morse code
//   o_count      current FIFO occupancy
//   o_empty      occupancy == 0
//   o_full       occupancy == DEPTH
//   o_overflow   sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module morse_char_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_ready,
  input  logic                     i_blk_ready,
  output logic [7:0]               o_char,
  output logic                     o_start,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic            r_rx_q;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_empty;
  logic            r_full;
  logic            r_overflow;
  logic [7:0]      r_char;
  logic            r_start;
  logic [TW-1:0]   r_to_cnt;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t          w_state_next;
  logic            w_push;
  logic            w_is_eol;
  logic            w_is_lower;
  logic [7:0]      w_wr_data;
  logic            w_wr_req;
  logic            w_wr_en;
  logic            w_drop;
  logic            w_pop;
  logic            w_to_clr;
  logic            w_to_inc;
  logic [CW-1:0]   w_count_next;

  // ---------------------------------------------------------------------------
  // Receive edge detect and byte normalisation
  // ---------------------------------------------------------------------------
  // A held-high receiver flag must push only once, so only the 0->1 edge counts.
  assign w_push     = i_rx_ready & ~r_rx_q;
  assign w_is_eol   = (i_rx_data == 8'h0D) | (i_rx_data == 8'h0A);
  assign w_is_lower = (i_rx_data >= 8'h61) & (i_rx_data <= 8'h7A);

  // Every byte in 0x61..0x7A has bit 5 set. Subtracting 0x20 is therefore the
  // same as clearing that bit, with no carry into the other bits.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fold
      if (gi == 5) begin : g_case_bit
        assign w_wr_data[gi] = i_rx_data[gi] & ~w_is_lower;
      end else begin : g_pass_bit
        assign w_wr_data[gi] = i_rx_data[gi];
      end
    end
  endgenerate

  assign w_wr_req = w_push & ~w_is_eol;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is accepted.
  assign w_wr_en  = w_wr_req & (~r_full | w_pop);
  assign w_drop   = w_wr_req & r_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_q <= 1'b0;
    end else begin
      r_rx_q <= i_rx_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: plain array, no reset, registered read into o_char
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_rst) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_char <= 8'h00;
    end else if (w_pop) begin
      r_char <= r_mem[r_rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and status flags
  // ---------------------------------------------------------------------------
  always_comb begin
    w_count_next = r_count;
    if (w_wr_en && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_en && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      // Flags come from the next count, so they always agree with o_count.
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CW'(DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_to_clr     = 1'b0;
    w_to_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && i_blk_ready) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_to_clr     = 1'b1;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!i_blk_ready) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          // The blinker never acknowledged. Treat the character as sent so
          // that a dead blinker cannot stall the queue.
          w_state_next = S_IDLE;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_blk_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // o_start is registered and is high for exactly the cycle spent in ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= (w_state_next == S_ISSUE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (w_to_clr) begin
      r_to_cnt <= '0;
    end else if (w_to_inc) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_char     = r_char;
  assign o_start    = r_start;
  assign o_count    = r_count;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_morse_char_queue.sv
// -----------------------------------------------------------------------------
// tb_morse_char_queue
//
// Bench for morse_char_queue. A behavioural model keeps the queue as a
// SystemVerilog queue. It tracks the in-flight character by its age in
// cycles since the pop. Every negedge, the DUT outputs are compared against
// this model. Directed scenarios add literal expectations. A randomised phase
// follows them.
// -----------------------------------------------------------------------------
module tb_morse_char_queue;

  localparam int DEPTH = 16;
  localparam int TO    = 1024;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          blk = 1'b1;
  logic [7:0]    o_char;
  logic          o_start;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_overflow;

  always #5 clk = ~clk;

  morse_char_queue #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .i_blk_ready (blk),
    .o_char      (o_char),
    .o_start     (o_start),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_char = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b0;
  bit         m_inflight = 1'b0;
  bit         m_dropped = 1'b0;
  int         m_age = 0;
  bit         chk_en = 1'b0;
  int         cyc = 0;
  bit         m_push;
  bit         m_pop;
  int         m_sz;
  logic [7:0] m_b;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_char     = 8'h00;
      m_ovf      = 1'b0;
      m_prev     = 1'b0;
      m_inflight = 1'b0;
      m_dropped  = 1'b0;
      m_age      = 0;
      chk_en     = 1'b1;
    end else begin
      m_push = rx_ready && !m_prev;
      m_prev = rx_ready;
      m_sz   = m_q.size();
      m_pop  = !m_inflight && (m_sz > 0) && blk;
      // In-flight character: age 0 is the start-pulse cycle. From age 2 on,
      // the blinker handshake is watched. Give up once TO cycles pass with no drop.
      if (m_inflight) begin
        m_age++;
        if (m_age >= 2) begin
          if (m_dropped) begin
            if (blk) m_inflight = 1'b0;
          end else if (!blk) begin
            m_dropped = 1'b1;
          end else if (m_age == TO + 1) begin
            m_inflight = 1'b0;
          end
        end
      end
      if (m_pop) begin
        m_char     = m_q.pop_front();
        m_inflight = 1'b1;
        m_age      = 0;
        m_dropped  = 1'b0;
      end
      if (m_push && rx_data != 8'h0D && rx_data != 8'h0A) begin
        m_b = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
        if (m_sz < DEPTH || m_pop) m_q.push_back(m_b);
        else m_ovf = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and start-pulse log
  // ---------------------------------------------------------------------------
  int         start_cnt = 0;
  logic [7:0] start_chars[$];
  int         start_cycs[$];
  int         max_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("start", o_start, m_inflight && m_age == 0);
      chk("char", o_char, m_char);
      chk("count", o_count, m_q.size());
      chk("empty", o_empty, m_q.size() == 0);
      chk("full", o_full, m_q.size() == DEPTH);
      chk("overflow", o_overflow, m_ovf);
      if (o_start === 1'b1) begin
        start_cnt++;
        start_chars.push_back(o_char);
        start_cycs.push_back(cyc);
      end
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    end
  end

  // ---------------------------------------------------------------------------
  // Blinker model: 0 always ready, 1 held busy, 2 drop 5 after start / play 20,
  // 3 random drop delay and play time
  // ---------------------------------------------------------------------------
  int blk_mode = 0;
  int b_ph = 0;
  int b_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      case (blk_mode)
        0: begin blk = 1'b1; b_ph = 0; end
        1: begin blk = 1'b0; b_ph = 0; end
        default: begin
          if (b_ph == 0) begin
            blk = 1'b1;
            if (o_start === 1'b1) begin
              b_ph  = 1;
              b_cnt = (blk_mode == 2) ? 5 : int'($urandom_range(1, 8));
            end
          end else if (b_ph == 1) begin
            b_cnt--;
            if (b_cnt == 0) begin
              blk   = 1'b0;
              b_ph  = 2;
              b_cnt = (blk_mode == 2) ? 20 : int'($urandom_range(1, 12));
            end
          end else begin
            b_cnt--;
            if (b_cnt == 0) begin
              blk  = 1'b1;
              b_ph = 0;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int push_cyc = 0;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    push_cyc = cyc + 1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    for (int i = 0; i < budget && start_cnt < target; i++) @(negedge clk);
    @(negedge clk);
    chk(name, start_cnt >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && (m_inflight || m_q.size() != 0); i++) @(negedge clk);
    chk(name, m_inflight || m_q.size() != 0, 0);
  endtask

  initial begin
    #(10_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int         s0;
  int         base;
  int         n;
  int         r;
  int         hold;
  int         gap;
  logic [7:0] exp_b [DEPTH+2];
  logic [7:0] rb;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_char", o_char, 8'h00);
    chk("rst_start", o_start, 0);
    rst = 1'b0;
    $display("reset released");

    // Single lowercase char: folded, one start in the cycle after the pop edge
    blk_mode = 0;
    s0 = start_cnt;
    send(8'h61);
    chk("single_cnt1", o_count, 1);
    wait_starts(s0 + 1, 10, "single_start_seen");
    chk("single_char", start_chars[start_chars.size()-1], 8'h41);
    chk("single_start_lat", start_cycs[start_cycs.size()-1] - push_cyc, 1);
    chk("single_cnt0", o_count, 0);
    repeat (5) @(negedge clk);
    chk("single_one_pulse", start_cnt - s0, 1);
    $display("single char 0x61 -> 0x%02h", start_chars[start_chars.size()-1]);
    wait_idle("single_idle");

    // CR/LF filtered
    s0 = start_cnt;
    max_cnt = 0;
    send(8'h0D);
    send(8'h0A);
    send(8'h37);
    wait_starts(s0 + 1, 10, "filter_start_seen");
    repeat (3) @(negedge clk);
    chk("filter_one_start", start_cnt - s0, 1);
    chk("filter_char", start_chars[start_chars.size()-1], 8'h37);
    chk("filter_max_cnt", max_cnt, 1);
    $display("filter CR,LF,0x37 -> %0d start(s)", start_cnt - s0);
    wait_idle("filter_idle");

    // Ordering with backpressure
    blk_mode = 1;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    base = start_chars.size();
    send(8'h41);
    send(8'h42);
    send(8'h43);
    repeat (3) @(negedge clk);
    chk("abc_count", o_count, 3);
    chk("abc_no_start", start_cnt - s0, 0);
    blk_mode = 2;
    wait_starts(s0 + 3, 600, "abc_starts_seen");
    for (int k = 0; k < 3; k++) chk("abc_order", start_chars[base+k], 8'h41 + k);
    $display("ABC backpressure: %0d chars issued", start_cnt - s0);
    wait_idle("abc_idle");

    // Full / overflow over three fill-drain passes
    for (int p = 0; p < 3; p++) begin
      blk_mode = 1;
      repeat (2) @(negedge clk);
      s0 = start_cnt;
      base = start_chars.size();
      for (int i = 0; i < DEPTH + 2; i++) begin
        exp_b[i] = 8'(8'h21 + p * 20 + i);
        send(exp_b[i]);
      end
      @(negedge clk);
      chk("ovf_full", o_full, 1);
      chk("ovf_count", o_count, DEPTH);
      chk("ovf_flag", o_overflow, 1);
      blk_mode = 2;
      wait_starts(s0 + DEPTH, 2000, "ovf_drain_seen");
      wait_idle("ovf_idle");
      chk("ovf_drained_n", start_cnt - s0, DEPTH);
      for (int i = 0; i < DEPTH; i++) chk("ovf_order", start_chars[base+i], exp_b[i]);
      $display("fill/drain pass %0d: %0d chars issued, overflow=%0d", p, start_cnt - s0, o_overflow);
    end

    // Timeout: blinker never drops ready
    blk_mode = 1;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    base = start_chars.size();
    send(8'h54);
    send(8'h4F);
    blk_mode = 0;
    wait_starts(s0 + 2, 3 * TO, "to_starts_seen");
    chk("to_gap", start_cycs[base+1] - start_cycs[base], TO + 2);
    chk("to_char0", start_chars[base], 8'h54);
    chk("to_char1", start_chars[base+1], 8'h4F);
    $display("timeout: start gap %0d cycles", start_cycs[base+1] - start_cycs[base]);
    wait_idle("to_idle");

    // Reset while the blinker is playing with 5 queued
    blk_mode = 2;
    for (int i = 0; i < 6; i++) send(8'h31 + 8'(i));
    chk("mid_setup_count", o_count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_count", o_count, 0);
    chk("mid_empty", o_empty, 1);
    chk("mid_ovf", o_overflow, 0);
    chk("mid_char", o_char, 8'h00);
    s0 = start_cnt;
    repeat (60) @(negedge clk);
    chk("mid_no_start", start_cnt - s0, 0);
    $display("mid-playback reset: count=%0d starts after=%0d", o_count, start_cnt - s0);

    // Randomised traffic
    blk_mode = 3;
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (r < 8) begin
        blk_mode = (blk_mode == 1) ? 3 : 1;
      end else begin
        n = int'($urandom_range(0, 7));
        if (n == 0) rb = 8'h0D;
        else if (n == 1) rb = 8'h0A;
        else if (n < 4) rb = 8'(8'h61 + $urandom_range(0, 25));
        else rb = 8'($urandom_range(0, 255));
        hold = int'($urandom_range(1, 3));
        gap  = int'($urandom_range(1, 3));
        @(negedge clk);
        rx_data  = rb;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    blk_mode = 3;
    wait_idle("rand_idle");
    $display("random phase: %0d starts total", start_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
